mix_columns_iter: RTL and testbench

Sequential, column-serial AES MixColumns/InvMixColumns engine that replaces the purely combinational MixColumns in the round datapath.
- Processes COLS_PER_CYCLE columns per clock, trading area against latency.
- Direction is selected per transaction at run time, not at elaboration.
- Sits between ShiftRows and AddRoundKey, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/mix_columns_iter_if.sv | 20 ++
 rtl/mix_columns_iter_col.sv | 36 +++
 rtl/mix_columns_iter.sv | 145 ++++++++++++++
 tb/tb_mix_columns_iter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic over x^8+x^4+x^3+x+1 and the
// MixColumns engine state encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the MixColumns/InvMixColumns coefficients are supported.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] p;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   p = b;
      8'h02:   p = x2;
      8'h03:   p = x2 ^ b;
      8'h09:   p = x8 ^ b;
      8'h0b:   p = x8 ^ x2 ^ b;
      8'h0d:   p = x8 ^ x4 ^ b;
      8'h0e:   p = x8 ^ x4 ^ x2;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Upstream/downstream valid-ready bundle for the MixColumns engine.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic         in_dec;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;

  modport master (
    output in_valid, in_data, in_dec, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dec, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_iter_col.sv
// One AES column through the forward [02 03 01 01] or inverse [0e 0b 0d 09]
// circulant matrix; byte 0 of the column sits in col[31:24].
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        dec,
  output logic [31:0] res
);

  logic [7:0] a_s    [4];
  logic [7:0] coef_s [4];
  logic [7:0] acc_s;

  // Row r uses the first matrix row rotated right by r positions.
  always_comb begin
    res   = 32'h0000_0000;
    acc_s = 8'h00;
    for (int i = 0; i < 4; i++) begin
      a_s[i] = col[31 - 8*i -: 8];
    end
    if (dec) begin
      coef_s[0] = 8'h0e; coef_s[1] = 8'h0b; coef_s[2] = 8'h0d; coef_s[3] = 8'h09;
    end else begin
      coef_s[0] = 8'h02; coef_s[1] = 8'h03; coef_s[2] = 8'h01; coef_s[3] = 8'h01;
    end
    for (int r = 0; r < 4; r++) begin
      acc_s = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc_s = acc_s ^ gf_mul(a_s[j], coef_s[2'(j - r + 4)]);
      end
      res[31 - 8*r -: 8] = acc_s;
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Column-serial MixColumns/InvMixColumns engine: transforms COLS_PER_CYCLE
// columns per clock in place, direction latched per transaction.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int OUT_REG        = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  mix_columns_iter_if.slave bus,
  output logic             busy
);

  localparam int         C         = COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(4 / C - 1);

  generate
    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  mc_state_t    state_r;
  mc_state_t    state_next_s;
  logic [1:0]   cnt_r;
  logic         dec_r;
  logic [0:127] work_r;
  logic [0:127] work_next_s;
  logic [0:127] out_data_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         in_ready_s;
  logic         accept_s;
  logic         last_beat_s;
  logic [1:0]   col_idx_s  [C];
  logic [31:0]  col_in_s   [C];
  logic [31:0]  col_out_s  [C];

  // Counter-driven column select feeding the column transformers.
  always_comb begin
    for (int k = 0; k < C; k++) begin
      col_idx_s[k] = 2'(int'(cnt_r) * C + k);
      col_in_s[k]  = work_r[{col_idx_s[k], 5'd0} +: 32];
    end
  end

  generate
    for (genvar k = 0; k < C; k++) begin : g_col
      mix_single_column u_col (
        .col (col_in_s[k]),
        .dec (dec_r),
        .res (col_out_s[k])
      );
    end
  endgenerate

  // Write the freshly transformed columns back over their originals.
  always_comb begin
    work_next_s = work_r;
    for (int k = 0; k < C; k++) begin
      work_next_s[{col_idx_s[k], 5'd0} +: 32] = col_out_s[k];
    end
  end

  assign last_beat_s = (state_r == BUSY) && (cnt_r == LAST_BEAT);
  assign accept_s    = bus.in_valid & in_ready_s;

  // Next-state and upstream ready; DONE may hand off straight into BUSY.
  always_comb begin
    in_ready_s   = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_BEAT) begin
          if ((OUT_REG == 0) && bus.out_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        in_ready_s = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_next_s = BUSY;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, working register, latched mode and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      dec_r       <= 1'b0;
      work_r      <= 128'h0;
      out_data_r  <= 128'h0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
      if (accept_s) begin
        work_r <= bus.in_data;
        dec_r  <= bus.in_dec;
        cnt_r  <= 2'd0;
      end else if (state_r == BUSY) begin
        work_r <= work_next_s;
        cnt_r  <= cnt_r + 2'd1;
      end
      if (last_beat_s) begin
        out_data_r <= work_next_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s & rst_n;
  assign bus.out_valid = out_valid_r | ((OUT_REG == 0) & last_beat_s);
  assign bus.out_data  = ((OUT_REG == 0) && last_beat_s) ? work_next_s : out_data_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench: four engine configurations against a generic GF(2^8)
// matrix model plus FIPS-197 known answers.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]   iv, idec, ordy;
  logic [0:127] id [4];
  wire  [3:0]   ov, ir, bz;
  wire  [0:127] od [4];

  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;
  int lat_tab [4] = '{5, 3, 2, 4};

  localparam logic [0:127] FIPS_A = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [0:127] FIPS_B = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [0:127] RND_I  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] RND_O  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] BP_I   = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
  localparam logic [0:127] BP_O   = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;

  // dut 0: C=1 registered, 1: C=2, 2: C=4, 3: C=1 combinational output
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CP = (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam int OR = (g == 3) ? 0 : 1;
    mix_columns_iter_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.in_data   = id[g];
    assign bus.in_dec    = idec[g];
    assign bus.out_ready = ordy[g];
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign od[g] = bus.out_data;
    mix_columns_iter #(.COLS_PER_CYCLE(CP), .OUT_REG(OR)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (bz[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y  = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_mc(input logic [0:127] s, input logic dec);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [0:127] r = 128'h0;
    if (dec) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[32*c + 8*i +: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - row + 4) % 4]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a state, wait for the accept edge, then for out_valid. Latency
  // counts rising edges from the accept edge (inclusive) to the one after
  // which out_valid is seen high.
  task automatic send(input int g, input logic [0:127] din, input logic d, output int lat);
    int t = 0;
    id[g] = din; idec[g] = d; iv[g] = 1'b1;
    while (!ir[g] && t < 20) begin tick(); t++; end
    chk("accept_ready", 128'(ir[g]), 128'(1'b1));
    tick();
    iv[g] = 1'b0;
    lat = 1;
    while (!ov[g] && lat < 20) begin tick(); lat++; end
    chk("out_valid_seen", 128'(ov[g]), 128'(1'b1));
    n_vec++;
  endtask

  task automatic txn(input int g, input logic [0:127] din, input logic d, input string tag);
    int lat;
    ordy[g] = 1'b1;
    send(g, din, d, lat);
    chk({tag, "_latency"}, 128'(lat), 128'(lat_tab[g]));
    chk({tag, "_data"}, od[g], ref_mc(din, d));
    tick();
    chk({tag, "_valid_drop"}, 128'(ov[g]), 128'(1'b0));
  endtask

  initial begin
    int lat;
    logic [0:127] rv;
    logic rd;
    rst_n = 1'b0; iv = 4'h0; idec = 4'h0; ordy = 4'hF;
    for (int k = 0; k < 4; k++) id[k] = 128'h0;
    #12;
    chk("rst_in_ready", 128'(ir), 128'(4'h0));
    chk("rst_out_valid", 128'(ov), 128'(4'h0));
    chk("rst_busy", 128'(bz), 128'(4'h0));
    chk("rst_out_data", od[0], 128'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 128'(ir), 128'(4'hF));

    txn(0, FIPS_A, 1'b0, "fips_fwd");
    chk("fips_fwd_kat", od[0], FIPS_B);
    txn(0, FIPS_B, 1'b1, "fips_inv");
    chk("fips_inv_kat", od[0], FIPS_A);
    for (int g = 0; g < 4; g++) begin
      txn(g, RND_I, 1'b0, "appb");
      chk("appb_kat", od[g], RND_O);
    end

    // Backpressure on dut 0, then same-edge hand-off to a new state.
    ordy[0] = 1'b0;
    send(0, RND_I, 1'b0, lat);
    chk("bp_latency", 128'(lat), 128'(5));
    id[0] = BP_I; idec[0] = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", 128'(ov[0]), 128'(1'b1));
      chk("bp_in_ready_low", 128'(ir[0]), 128'(1'b0));
      chk("bp_data_hold", od[0], RND_O);
    end
    ordy[0] = 1'b1;
    tick();
    chk("handoff_valid_low", 128'(ov[0]), 128'(1'b0));
    chk("handoff_busy", 128'(bz[0]), 128'(1'b1));
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      id[0] = {$urandom, $urandom, $urandom, $urandom};
      idec[0] = 1'b1;
      tick(); lat++;
    end
    iv[0] = 1'b0;
    while (!ov[0] && lat < 20) begin tick(); lat++; end
    n_vec++;
    chk("handoff_latency", 128'(lat), 128'(5));
    chk("handoff_kat", od[0], BP_O);
    chk("handoff_model", od[0], ref_mc(BP_I, 1'b0));
    tick();

    // Combinational-output variant held in DONE by backpressure.
    ordy[3] = 1'b0;
    rv = {$urandom, $urandom, $urandom, $urandom};
    send(3, rv, 1'b1, lat);
    chk("comb_latency", 128'(lat), 128'(4));
    chk("comb_last_beat_data", od[3], ref_mc(rv, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("comb_done_valid", 128'(ov[3]), 128'(1'b1));
      chk("comb_done_data", od[3], ref_mc(rv, 1'b1));
    end
    ordy[3] = 1'b1;
    tick();
    chk("comb_valid_drop", 128'(ov[3]), 128'(1'b0));

    // Reset at beat 2 of a C=1 transaction aborts it.
    id[0] = FIPS_A; idec[0] = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(ov[0]), 128'(1'b0));
    chk("abort_busy", 128'(bz[0]), 128'(1'b0));
    chk("abort_in_ready", 128'(ir[0]), 128'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_output", 128'(ov[0]), 128'(1'b0));
    end
    chk("abort_idle", 128'(ir[0]), 128'(1'b1));
    txn(0, RND_I, 1'b0, "post_abort");

    // Mode switch on consecutive accepts with identical data.
    ordy[0] = 1'b1;
    send(0, RND_I, 1'b0, lat);
    chk("mode_fwd", od[0], ref_mc(RND_I, 1'b0));
    iv[0] = 1'b1; idec[0] = 1'b1; id[0] = RND_I;
    tick();
    iv[0] = 1'b0;
    chk("mode_fwd_held", od[0], RND_O);
    lat = 1;
    while (!ov[0] && lat < 20) begin tick(); lat++; end
    n_vec++;
    chk("mode_inv_latency", 128'(lat), 128'(5));
    chk("mode_inv", od[0], ref_mc(RND_I, 1'b1));
    tick();

    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 6; i++) begin
        rv = {$urandom, $urandom, $urandom, $urandom};
        rd = 1'($urandom_range(0, 1));
        txn(g, rv, rd, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
